// File: rtl/vic_wb_buffer_pkg.sv
// Shared types for the victim-cache write-back buffer: eviction line format,
// memory bus command, buffer entry and the drain FSM state.
package vic_wb_buffer_pkg;

  localparam int NUM_SET_BITS = 4;
  localparam int NUM_TAG_BITS = 13;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef struct packed {
    logic [NUM_TAG_BITS-1:0] tag;
    logic [63:0]             data;
    logic                    valid;
    logic                    dirty;
  } VIC_LINE_T;

  typedef struct packed {
    VIC_LINE_T               line;
    logic [NUM_SET_BITS-1:0] idx;
  } VIC_CACHE_T;

  typedef struct packed {
    logic [NUM_TAG_BITS-1:0] tag;
    logic [NUM_SET_BITS-1:0] idx;
    logic [63:0]             data;
    logic                    valid;
  } WB_ENTRY_T;

  localparam WB_ENTRY_T EMPTY_WB_ENTRY = '0;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_REQ  = 1'b1
  } WB_STATE_T;

  function automatic logic wb_key_match(input WB_ENTRY_T e,
                                        input logic [NUM_TAG_BITS-1:0] tag,
                                        input logic [NUM_SET_BITS-1:0] idx);
    return e.valid && (e.tag == tag) && (e.idx == idx);
  endfunction

endpackage

// File: rtl/vic_wb_buffer_if.sv
// Memory-bus handshake between the write-back buffer (master) and the
// bus arbiter / memory side (slave).
interface vic_wb_buffer_if;
  import vic_wb_buffer_pkg::*;

  logic        wb_req;
  logic        mem_grant;
  BUS_COMMAND  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;

  modport master (
    output wb_req, proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem_grant, mem2proc_response
  );

  modport slave (
    input  wb_req, proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem_grant, mem2proc_response
  );
endinterface

// File: rtl/vic_wb_buffer_compact.sv
// Packs the dirty, valid evictions of one cycle into contiguous slots,
// port 0 first, and reports how many there are.
module vic_wb_buffer_compact
  import vic_wb_buffer_pkg::*;
#(
  parameter int IN_PORTS = 3
) (
  input  VIC_CACHE_T [IN_PORTS-1:0]         i_vic,
  input  logic       [IN_PORTS-1:0]         i_valid,
  output WB_ENTRY_T  [IN_PORTS-1:0]         o_packed,
  output logic [$clog2(IN_PORTS+1)-1:0]     o_count
);

  localparam int QC_W = $clog2(IN_PORTS+1);

  always_comb begin
    o_packed = '{default: EMPTY_WB_ENTRY};
    o_count  = '0;
    for (int i = 0; i < IN_PORTS; i++) begin
      if (i_valid[i] && i_vic[i].line.valid && i_vic[i].line.dirty) begin
        o_packed[o_count] = '{tag:   i_vic[i].line.tag,
                              idx:   i_vic[i].idx,
                              data:  i_vic[i].line.data,
                              valid: 1'b1};
        o_count = o_count + QC_W'(1);
      end
    end
  end

endmodule

// File: rtl/vic_wb_buffer.sv
// Age-ordered write-back buffer for dirty victim lines: enqueues evictions,
// drains them as bus stores and offers a forwarding lookup on pending lines.
module vic_wb_buffer
  import vic_wb_buffer_pkg::*;
#(
  parameter int IN_PORTS     = 3,
  parameter int WB_DEPTH     = 4,
  parameter int BLK_OFF_BITS = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  VIC_CACHE_T [IN_PORTS-1:0]     evicted_vic,
  input  logic [IN_PORTS-1:0]           evicted_valid,
  output logic [$clog2(WB_DEPTH):0]     free_count,
  output logic                          overflow_err,
  input  logic                          lookup_en,
  input  logic [NUM_SET_BITS-1:0]       lookup_idx,
  input  logic [NUM_TAG_BITS-1:0]       lookup_tag,
  output logic                          lookup_hit,
  output logic [63:0]                   lookup_data,
  vic_wb_buffer_if.master               bus,
  input  logic                          flush_req,
  output logic                          flush_done
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int QC_W  = $clog2(IN_PORTS+1);

  WB_ENTRY_T              r_entries [WB_DEPTH];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;
  logic                   r_ovf;
  WB_STATE_T              r_state;
  WB_STATE_T              w_state_next;

  WB_ENTRY_T [IN_PORTS-1:0] w_packed;
  logic [QC_W-1:0]        w_nqual;
  logic [CNT_W-1:0]       w_nqual_ext;
  logic [CNT_W-1:0]       w_free;
  logic [CNT_W-1:0]       w_accept;
  logic [CNT_W-1:0]       w_count_next;
  logic                   w_deq;
  logic                   w_issue;

  vic_wb_buffer_compact #(.IN_PORTS(IN_PORTS)) u_compact (
    .i_vic    (evicted_vic),
    .i_valid  (evicted_valid),
    .o_packed (w_packed),
    .o_count  (w_nqual)
  );

  // Capacity is judged from registered occupancy only; a same-cycle drain frees nothing.
  always_comb begin
    w_free      = CNT_W'(WB_DEPTH) - r_count;
    w_nqual_ext = CNT_W'(w_nqual);
    w_accept    = (w_nqual_ext > w_free) ? w_free : w_nqual_ext;
    w_deq       = (r_state == WB_REQ) && bus.mem_grant &&
                  (bus.mem2proc_response != 4'h0) && (r_count != '0);
    w_count_next = r_count + w_accept - CNT_W'(w_deq);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < WB_DEPTH; i++) r_entries[i].valid <= 1'b0;
    end else begin
      if (w_deq) begin
        r_entries[r_head].valid <= 1'b0;
        r_head <= r_head + PTR_W'(1);
      end
      for (int k = 0; k < IN_PORTS; k++) begin
        if (CNT_W'(k) < w_accept) r_entries[r_tail + PTR_W'(k)] <= w_packed[k];
      end
      r_tail  <= r_tail + PTR_W'(w_accept);
      r_count <= w_count_next;
      if (w_nqual_ext > w_free) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) r_state <= WB_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WB_IDLE: if (r_count != '0) w_state_next = WB_REQ;
      WB_REQ:  if (w_deq && (w_count_next == '0)) w_state_next = WB_IDLE;
      default: w_state_next = WB_IDLE;
    endcase
  end

  always_comb begin
    w_issue              = (r_state == WB_REQ) && bus.mem_grant;
    bus.wb_req           = (r_state == WB_REQ) || (r_count != '0);
    bus.proc2mem_command = w_issue ? BUS_STORE : BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    if (w_issue) begin
      bus.proc2mem_addr = 64'({r_entries[r_head].tag, r_entries[r_head].idx,
                               {BLK_OFF_BITS{1'b0}}});
      bus.proc2mem_data = r_entries[r_head].data;
    end
  end

  // Walk from oldest to youngest so the last match seen is the youngest.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    if (lookup_en) begin
      for (int k = 0; k < WB_DEPTH; k++) begin
        if (wb_key_match(r_entries[r_head + PTR_W'(k)], lookup_tag, lookup_idx)) begin
          lookup_hit  = 1'b1;
          lookup_data = r_entries[r_head + PTR_W'(k)].data;
        end
      end
    end
  end

  assign free_count   = w_free;
  assign overflow_err = r_ovf;
  assign flush_done   = flush_req && (r_count == '0);

endmodule

// File: tb/tb_vic_wb_buffer.sv
// Bench for vic_wb_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vic_wb_buffer;
  import vic_wb_buffer_pkg::*;

  localparam int IN_PORTS     = 3;
  localparam int WB_DEPTH     = 4;
  localparam int BLK_OFF_BITS = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  VIC_CACHE_T [IN_PORTS-1:0]   evicted_vic;
  logic [IN_PORTS-1:0]         evicted_valid;
  logic [$clog2(WB_DEPTH):0]   free_count;
  logic                        overflow_err;
  logic                        lookup_en;
  logic [NUM_SET_BITS-1:0]     lookup_idx;
  logic [NUM_TAG_BITS-1:0]     lookup_tag;
  logic                        lookup_hit;
  logic [63:0]                 lookup_data;
  logic                        flush_req;
  logic                        flush_done;

  vic_wb_buffer_if bus ();

  vic_wb_buffer #(.IN_PORTS(IN_PORTS), .WB_DEPTH(WB_DEPTH), .BLK_OFF_BITS(BLK_OFF_BITS)) dut (
    .clock         (clock),
    .reset         (reset),
    .evicted_vic   (evicted_vic),
    .evicted_valid (evicted_valid),
    .free_count    (free_count),
    .overflow_err  (overflow_err),
    .lookup_en     (lookup_en),
    .lookup_idx    (lookup_idx),
    .lookup_tag    (lookup_tag),
    .lookup_hit    (lookup_hit),
    .lookup_data   (lookup_data),
    .bus           (bus.master),
    .flush_req     (flush_req),
    .flush_done    (flush_done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [NUM_TAG_BITS-1:0] tag;
    logic [NUM_SET_BITS-1:0] idx;
    logic [63:0]             data;
  } m_ent_t;

  m_ent_t mq[$];
  m_ent_t m_arr[$];
  bit     m_req  = 1'b0;
  bit     m_ovf  = 1'b0;
  bit     m_init = 1'b0;
  int     m_old, m_free;
  bit     m_deq;

  function automatic logic [63:0] m_addr(input m_ent_t e);
    return 64'({e.tag, e.idx, 3'b000});
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      mq.delete();
      m_req  = 1'b0;
      m_ovf  = 1'b0;
      m_init = 1'b1;
    end else if (m_init) begin
      m_old  = mq.size();
      m_free = WB_DEPTH - m_old;
      m_deq  = m_req && bus.mem_grant && (bus.mem2proc_response != 4'h0) && (m_old > 0);
      m_arr.delete();
      for (int i = 0; i < IN_PORTS; i++)
        if (evicted_valid[i] && evicted_vic[i].line.valid && evicted_vic[i].line.dirty)
          m_arr.push_back('{tag: evicted_vic[i].line.tag, idx: evicted_vic[i].idx,
                            data: evicted_vic[i].line.data});
      if (m_arr.size() > m_free) m_ovf = 1'b1;
      if (m_deq) void'(mq.pop_front());
      for (int i = 0; i < m_arr.size() && i < m_free; i++) mq.push_back(m_arr[i]);
      if (!m_req) m_req = (m_old != 0);
      else if (m_deq && mq.size() == 0) m_req = 1'b0;
    end
  end

  bit          e_issue, e_hit;
  logic [63:0] e_ldata, e_addr, e_data;

  always @(negedge clock) begin
    if (m_init) begin
      e_issue = m_req && bus.mem_grant;
      e_addr  = (e_issue && mq.size() > 0) ? m_addr(mq[0]) : 64'h0;
      e_data  = (e_issue && mq.size() > 0) ? mq[0].data : 64'h0;
      e_hit   = 1'b0;
      e_ldata = 64'h0;
      if (lookup_en)
        for (int k = mq.size() - 1; k >= 0; k--)
          if (mq[k].tag == lookup_tag && mq[k].idx == lookup_idx) begin
            e_hit = 1'b1; e_ldata = mq[k].data; break;
          end
      check("m_free", 64'(free_count), 64'(WB_DEPTH - mq.size()));
      check("m_ovf", 64'(overflow_err), 64'(m_ovf));
      check("m_wbreq", 64'(bus.wb_req), 64'(m_req || mq.size() != 0));
      check("m_cmd", 64'(bus.proc2mem_command), e_issue ? 64'(BUS_STORE) : 64'(BUS_NONE));
      check("m_addr", bus.proc2mem_addr, e_addr);
      check("m_data", bus.proc2mem_data, e_data);
      check("m_hit", 64'(lookup_hit), 64'(e_hit));
      check("m_ldata", lookup_data, e_ldata);
      check("m_flush", 64'(flush_done), 64'(flush_req && mq.size() == 0));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic VIC_CACHE_T mk(input logic v, input logic d, input logic [NUM_TAG_BITS-1:0] t,
                                    input logic [NUM_SET_BITS-1:0] ix, input logic [63:0] dt);
    VIC_CACHE_T e;
    e.line.valid = v; e.line.dirty = d; e.line.tag = t; e.line.data = dt; e.idx = ix;
    return e;
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic idle_inputs();
    evicted_valid = '0;
    evicted_vic   = '0;
    bus.mem_grant = 1'b0;
    bus.mem2proc_response = 4'h0;
    lookup_en  = 1'b0;
    lookup_tag = '0;
    lookup_idx = '0;
    flush_req  = 1'b0;
  endtask

  task automatic drain_all();
    bit done = 1'b0;
    bus.mem_grant = 1'b1;
    bus.mem2proc_response = 4'h1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      if (free_count == 3'(WB_DEPTH)) done = 1'b1;
      else tick();
    end
    check("drain_done", 64'(free_count), 64'(WB_DEPTH));
    bus.mem_grant = 1'b0;
    bus.mem2proc_response = 4'h0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    logic [63:0] a;
    idle_inputs();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    flush_req = 1'b1; lookup_en = 1'b1; lookup_tag = 13'h5; lookup_idx = 4'h2;
    @(negedge clock);
    check("rst_free", 64'(free_count), 64'd4);
    check("rst_wbreq", 64'(bus.wb_req), 64'd0);
    check("rst_cmd", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    check("rst_ovf", 64'(overflow_err), 64'd0);
    check("rst_addr", bus.proc2mem_addr, 64'd0);
    check("rst_data", bus.proc2mem_data, 64'd0);
    check("rst_hit", 64'(lookup_hit), 64'd0);
    check("rst_flush", 64'(flush_done), 64'd1);

    // ports 0 and 2 dirty, port 1 clean
    idle_inputs();
    evicted_valid  = 3'b111;
    evicted_vic[0] = mk(1'b1, 1'b1, 13'h101, 4'h1, 64'h1111_0000);
    evicted_vic[1] = mk(1'b1, 1'b0, 13'h202, 4'h2, 64'h2222);
    evicted_vic[2] = mk(1'b1, 1'b1, 13'h303, 4'h3, 64'h3333);
    tick();
    idle_inputs();
    lookup_en = 1'b1; lookup_tag = 13'h202; lookup_idx = 4'h2;
    @(negedge clock);
    check("enq_free", 64'(free_count), 64'd2);
    check("clean_miss", 64'(lookup_hit), 64'd0);
    check("enq_wbreq", 64'(bus.wb_req), 64'd1);
    #1 lookup_tag = 13'h101; lookup_idx = 4'h1;
    #1 check("p0_hit", 64'(lookup_hit), 64'd1);
    check("p0_ldata", lookup_data, 64'h1111_0000);
    tick();
    bus.mem_grant = 1'b1; bus.mem2proc_response = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("retry_cmd", 64'(bus.proc2mem_command), 64'(BUS_STORE));
      check("retry_addr", bus.proc2mem_addr, 64'h8088);
      check("retry_data", bus.proc2mem_data, 64'h1111_0000);
      tick();
    end
    bus.mem2proc_response = 4'h5;
    @(negedge clock);
    check("acc_addr", bus.proc2mem_addr, 64'h8088);
    tick();
    bus.mem_grant = 1'b0; bus.mem2proc_response = 4'h0;
    @(negedge clock);
    check("acc_free", 64'(free_count), 64'd3);
    bus.mem_grant = 1'b1; bus.mem2proc_response = 4'h1;
    #1 check("p2_addr", bus.proc2mem_addr, 64'h1_8198);
    check("p2_data", bus.proc2mem_data, 64'h3333);
    tick();
    idle_inputs();
    @(negedge clock);
    check("empty_free", 64'(free_count), 64'd4);
    check("empty_wbreq", 64'(bus.wb_req), 64'd0);

    // fill to capacity, then overflow on the accept cycle
    evicted_valid = 3'b111;
    for (int i = 0; i < 3; i++) evicted_vic[i] = mk(1'b1, 1'b1, 13'(16 + i), 4'(i), 64'(100 + i));
    tick();
    evicted_valid = 3'b001;
    evicted_vic[0] = mk(1'b1, 1'b1, 13'h13, 4'h3, 64'd103);
    tick();
    idle_inputs();
    @(negedge clock);
    check("full_free", 64'(free_count), 64'd0);
    check("full_ovf", 64'(overflow_err), 64'd0);
    bus.mem_grant = 1'b1; bus.mem2proc_response = 4'h1;
    evicted_valid = 3'b111;
    for (int i = 0; i < 3; i++) evicted_vic[i] = mk(1'b1, 1'b1, 13'(32 + i), 4'(i), 64'(200 + i));
    tick();
    idle_inputs();
    @(negedge clock);
    check("ovf_set", 64'(overflow_err), 64'd1);
    check("ovf_free", 64'(free_count), 64'd1);
    repeat (3) tick();
    @(negedge clock);
    check("ovf_sticky", 64'(overflow_err), 64'd1);
    drain_all();

    // duplicate key: youngest wins, same-cycle arrival invisible
    idle_inputs();
    evicted_valid  = 3'b011;
    evicted_vic[0] = mk(1'b1, 1'b1, 13'h777, 4'h5, 64'hAAAA);
    evicted_vic[1] = mk(1'b1, 1'b1, 13'h777, 4'h5, 64'hBBBB);
    lookup_en = 1'b1; lookup_tag = 13'h777; lookup_idx = 4'h5;
    #1 check("same_cycle_miss", 64'(lookup_hit), 64'd0);
    tick();
    evicted_valid = '0;
    @(negedge clock);
    check("dup_hit", 64'(lookup_hit), 64'd1);
    check("dup_data", lookup_data, 64'hBBBB);
    drain_all();

    // wrap-around: ten single enqueues, each drained
    for (int n = 0; n < 10; n++) begin
      idle_inputs();
      evicted_valid  = 3'b001;
      evicted_vic[0] = mk(1'b1, 1'b1, 13'(n + 64), 4'(n), 64'(n * 3 + 7));
      tick();
      evicted_valid = '0;
      bus.mem_grant = 1'b1; bus.mem2proc_response = 4'h1;
      flush_req = (n == 9);
      got = 1'b0; a = '0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clock);
        if (n == 9 && i == 0) check("flush_busy", 64'(flush_done), 64'd0);
        if (bus.proc2mem_command == BUS_STORE) begin got = 1'b1; a = bus.proc2mem_addr; end
        tick();
      end
      check("wrap_found", 64'(got), 64'd1);
      check("wrap_addr", a, 64'({13'(n + 64), 4'(n), 3'b000}));
    end
    idle_inputs();
    flush_req = 1'b1;
    @(negedge clock);
    check("flush_done", 64'(flush_done), 64'd1);

    // reset in the middle of a pending store
    idle_inputs();
    evicted_valid  = 3'b001;
    evicted_vic[0] = mk(1'b1, 1'b1, 13'h55, 4'h7, 64'h5555);
    tick();
    idle_inputs();
    tick();
    bus.mem_grant = 1'b1; bus.mem2proc_response = 4'h0;
    @(negedge clock);
    check("mid_cmd", 64'(bus.proc2mem_command), 64'(BUS_STORE));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_cmd", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    check("mid_rst_free", 64'(free_count), 64'd4);
    check("mid_rst_ovf", 64'(overflow_err), 64'd0);
    tick();
    @(negedge clock);
    check("no_retry_cmd", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    check("no_retry_req", 64'(bus.wb_req), 64'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(0, 255) != 0);
      for (int i = 0; i < IN_PORTS; i++) begin
        evicted_valid[i] = 1'($urandom_range(0, 1));
        evicted_vic[i]   = mk(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                              13'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                              {$urandom, $urandom});
      end
      if (free_count < 3'(IN_PORTS) && $urandom_range(0, 3) != 0) evicted_valid = '0;
      bus.mem_grant = ($urandom_range(0, 3) != 0);
      bus.mem2proc_response = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      lookup_en  = 1'($urandom_range(0, 1));
      lookup_tag = 13'($urandom_range(0, 3));
      lookup_idx = 4'($urandom_range(0, 3));
      flush_req  = 1'($urandom_range(0, 1));
    end
    tick();
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
